// File: rtl/apb_arbiter.sv
// apb_arbiter: two-master APB arbiter with zero-latency routing and round-robin tie break.
// Defining APB_ARB_TIMEOUT_EN adds a watchdog that terminates hung transfers with an error.
module apb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              APB_PCLK,
  input  logic              APB_PRESET,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_perr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_perr,
  output logic              s_psel,
  output logic              s_penable,
  output logic              s_pwrite,
  output logic [ADDR_W-1:0] s_paddr,
  output logic [DATA_W-1:0] s_pwdata,
  input  logic [DATA_W-1:0] s_prdata,
  input  logic              s_pready,
  input  logic              s_perr,
  output logic              gnt,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic        owner_r, owner_nxt_s;
  logic        last_r, last_nxt_s;
  logic        gnt_s;
  logic        g_psel_s, g_penable_s, g_pwrite_s;
  logic [ADDR_W-1:0] g_paddr_s;
  logic [DATA_W-1:0] g_pwdata_s;
  logic        s_psel_s;
  logic        done_s;
  logic        end_s;
  logic        block_s;
  logic        timeout_s;
  logic [DATA_W-1:0] rsp_prdata_s;
  logic        rsp_pready_s, rsp_perr_s;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("apb_arbiter: TIMEOUT must be at least 2");
  end

  // Owner selection: arbitrate only in IDLE, otherwise keep the current owner.
  always_comb begin
    gnt_s = owner_r;
    if (state_r == IDLE) begin
      if (m0_psel && !m1_psel) begin
        gnt_s = 1'b0;
      end else if (!m0_psel && m1_psel) begin
        gnt_s = 1'b1;
      end else if (m0_psel && m1_psel) begin
        gnt_s = ~last_r;
      end else begin
        gnt_s = owner_r;
      end
    end else begin
      gnt_s = owner_r;
    end
  end

  // Request mux for the granted master.
  always_comb begin
    if (gnt_s) begin
      g_psel_s    = m1_psel;
      g_penable_s = m1_penable;
      g_pwrite_s  = m1_pwrite;
      g_paddr_s   = m1_paddr;
      g_pwdata_s  = m1_pwdata;
    end else begin
      g_psel_s    = m0_psel;
      g_penable_s = m0_penable;
      g_pwrite_s  = m0_pwrite;
      g_paddr_s   = m0_paddr;
      g_pwdata_s  = m0_pwdata;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT);

  logic [WDOG_W-1:0] wdog_r;
  logic              block_r;
  logic              wait_s;

  // Watchdog terminates an access that has waited TIMEOUT cycles.
  always_comb begin
    wait_s    = s_psel_s & g_penable_s & ~s_pready;
    timeout_s = wait_s & (wdog_r == WDOG_W'(TIMEOUT - 1));
    block_s   = block_r;
  end

  // Watchdog counter and the one-cycle slave select block after a timeout.
  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      wdog_r  <= '0;
      block_r <= 1'b0;
    end else begin
      block_r <= timeout_s;
      if (wait_s && !timeout_s) begin
        wdog_r <= wdog_r + WDOG_W'(1);
      end else begin
        wdog_r <= '0;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign block_s   = 1'b0;
`endif

  // Completion terms and the response seen by the granted master.
  always_comb begin
    s_psel_s = g_psel_s & ~block_s;
    done_s   = s_psel_s & g_penable_s & s_pready;
    end_s    = done_s | timeout_s;
    if (timeout_s) begin
      rsp_prdata_s = '0;
      rsp_pready_s = 1'b1;
      rsp_perr_s   = 1'b1;
    end else begin
      rsp_prdata_s = s_prdata;
      rsp_pready_s = s_pready;
      rsp_perr_s   = s_perr;
    end
  end

  // Output routing; everything is held low while reset is asserted.
  always_comb begin
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    m0_prdata = '0;
    m0_pready = 1'b0;
    m0_perr   = 1'b0;
    m1_prdata = '0;
    m1_pready = 1'b0;
    m1_perr   = 1'b0;
    gnt       = 1'b0;
    busy      = 1'b0;
    if (!APB_PRESET) begin
      s_psel    = s_psel_s;
      s_penable = g_penable_s;
      s_pwrite  = g_pwrite_s;
      s_paddr   = g_paddr_s;
      s_pwdata  = g_pwdata_s;
      gnt       = gnt_s;
      busy      = (state_r == BUSY);
      if (gnt_s) begin
        m1_prdata = rsp_prdata_s;
        m1_pready = rsp_pready_s;
        m1_perr   = rsp_perr_s;
      end else begin
        m0_prdata = rsp_prdata_s;
        m0_pready = rsp_pready_s;
        m0_perr   = rsp_perr_s;
      end
    end else begin
      busy = 1'b0;
    end
  end

  // Next-state logic; an abort returns to IDLE without updating last.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (s_psel_s) begin
          if (end_s) begin
            last_nxt_s = gnt_s;
          end else begin
            state_nxt_s = BUSY;
            owner_nxt_s = gnt_s;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (end_s) begin
          state_nxt_s = IDLE;
          last_nxt_s  = owner_r;
        end else if (!g_psel_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State registers; reset makes m0 win the first tie.
  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter; inputs change 1ns after the rising edge and
// outputs are checked on the falling edge.
module tb_apb_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic APB_PCLK = 1'b0;
  logic APB_PRESET;
  logic m0_psel, m0_penable, m0_pwrite;
  logic [ADDR_W-1:0] m0_paddr;
  logic [DATA_W-1:0] m0_pwdata, m0_prdata;
  logic m0_pready, m0_perr;
  logic m1_psel, m1_penable, m1_pwrite;
  logic [ADDR_W-1:0] m1_paddr;
  logic [DATA_W-1:0] m1_pwdata, m1_prdata;
  logic m1_pready, m1_perr;
  logic s_psel, s_penable, s_pwrite;
  logic [ADDR_W-1:0] s_paddr;
  logic [DATA_W-1:0] s_pwdata, s_prdata;
  logic s_pready, s_perr;
  logic gnt, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 APB_PCLK = ~APB_PCLK;

  apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .APB_PCLK(APB_PCLK), .APB_PRESET(APB_PRESET),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
    .m0_pready(m0_pready), .m0_perr(m0_perr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
    .m1_pready(m1_pready), .m1_perr(m1_perr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
    .s_pready(s_pready), .s_perr(s_perr),
    .gnt(gnt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge APB_PCLK);
    #1;
  endtask

  task automatic settle();
    @(negedge APB_PCLK);
  endtask

  task automatic drop_all();
    m0_psel = 1'b0; m0_penable = 1'b0; m0_pwrite = 1'b0;
    m1_psel = 1'b0; m1_penable = 1'b0; m1_pwrite = 1'b0;
    s_pready = 1'b0; s_perr = 1'b0; s_prdata = 32'h0;
  endtask

  initial begin
    m0_paddr = 32'h0000_0100; m0_pwdata = 32'h0000_0000;
    m1_paddr = 32'h0000_0200; m1_pwdata = 32'h1111_1111;
    drop_all();
    // Reset with busy-looking inputs: every output must stay low.
    APB_PRESET = 1'b1;
    m0_psel = 1'b1; m0_penable = 1'b1; s_pready = 1'b1; s_prdata = 32'hFFFF_FFFF;
    settle();
    chk("rst_s_psel", s_psel, 1'b0);
    chk("rst_m0_pready", m0_pready, 1'b0);
    chk("rst_m0_prdata", m0_prdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 1'b0);
    tick();
    drop_all();
    tick();

    // m0 read of 0x10 completing on the first access cycle.
    APB_PRESET = 1'b0;
    m0_psel = 1'b1; m0_paddr = 32'h0000_0010;
    settle();
    chk("t1_setup_gnt", gnt, 1'b0);
    chk("t1_setup_s_psel", s_psel, 1'b1);
    chk("t1_setup_s_paddr", s_paddr, 32'h0000_0010);
    chk("t1_setup_m0_pready", m0_pready, 1'b0);
    tick();
    m0_penable = 1'b1; s_pready = 1'b1; s_prdata = 32'hA5A5_A5A5;
    settle();
    chk("t1_acc_busy", busy, 1'b1);
    chk("t1_acc_m0_prdata", m0_prdata, 32'hA5A5_A5A5);
    chk("t1_acc_m0_pready", m0_pready, 1'b1);
    chk("t1_acc_m1_pready", m1_pready, 1'b0);
    chk("t1_acc_m1_prdata", m1_prdata, 32'h0);
    tick();
    drop_all();
    settle();
    chk("t1_back_idle", busy, 1'b0);
    tick();

    // Re-reset so the next tie starts from the reset tie-break.
    APB_PRESET = 1'b1;
    tick();
    APB_PRESET = 1'b0;
    m0_paddr = 32'h0000_0100;
    m0_psel = 1'b1; m1_psel = 1'b1;
    settle();
    chk("t2_tie1_gnt", gnt, 1'b0);
    chk("t2_tie1_s_paddr", s_paddr, 32'h0000_0100);
    chk("t2_tie1_m1_pready", m1_pready, 1'b0);
    tick();
    m0_penable = 1'b1; s_pready = 1'b1; s_prdata = 32'h0000_5555;
    settle();
    chk("t2_m0done_pready", m0_pready, 1'b1);
    chk("t2_m0done_m1_pready", m1_pready, 1'b0);
    tick();
    // m0 immediately requests again; m1 has been waiting and wins this tie.
    m0_penable = 1'b0; s_pready = 1'b0;
    settle();
    chk("t2_tie2_gnt", gnt, 1'b1);
    chk("t2_tie2_s_paddr", s_paddr, 32'h0000_0200);
    chk("t2_tie2_m1_pready", m1_pready, 1'b0);
    chk("t2_tie2_m0_pready", m0_pready, 1'b0);
    tick();
    m1_penable = 1'b1; s_pready = 1'b1; s_prdata = 32'h0000_1234;
    settle();
    chk("t2_m1done_pready", m1_pready, 1'b1);
    chk("t2_m1done_prdata", m1_prdata, 32'h0000_1234);
    chk("t2_m1done_m0_prdata", m0_prdata, 32'h0);
    tick();
    m1_penable = 1'b0; s_pready = 1'b0;
    settle();
    chk("t2_tie3_gnt", gnt, 1'b0);
    tick();
    m1_psel = 1'b0; m0_penable = 1'b1; s_pready = 1'b1;
    settle();
    chk("t2_m0done2_pready", m0_pready, 1'b1);
    tick();
    drop_all();
    tick();

    // m1 owns the bus through 3 wait states while m0 requests mid-transfer.
    m1_psel = 1'b1; m1_paddr = 32'h0000_0300;
    settle();
    chk("t3_setup_gnt", gnt, 1'b1);
    tick();
    m1_penable = 1'b1; m0_psel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_pready = (i == 3) ? 1'b1 : 1'b0;
      settle();
      chk("t3_acc_s_paddr", s_paddr, 32'h0000_0300);
      chk("t3_acc_gnt", gnt, 1'b1);
      chk("t3_acc_m0_pready", m0_pready, 1'b0);
      chk("t3_acc_m1_pready", m1_pready, s_pready);
      tick();
    end
    m1_psel = 1'b0; m1_penable = 1'b0; s_pready = 1'b0;
    settle();
    chk("t3_m0_after_gnt", gnt, 1'b0);
    chk("t3_m0_after_s_paddr", s_paddr, 32'h0000_0100);
    tick();
    m0_penable = 1'b1; s_pready = 1'b1;
    tick();
    drop_all();
    tick();

    // Reset mid-transfer with m1 as owner.
    m1_psel = 1'b1;
    tick();
    m1_penable = 1'b1;
    settle();
    chk("t4_busy_before_rst", busy, 1'b1);
    APB_PRESET = 1'b1;
    #1;
    chk("t4_rst_s_psel", s_psel, 1'b0);
    chk("t4_rst_m1_pready", m1_pready, 1'b0);
    tick();
    APB_PRESET = 1'b0;
    m1_penable = 1'b0; m0_psel = 1'b1;
    settle();
    chk("t4_after_busy", busy, 1'b0);
    chk("t4_after_tie_gnt", gnt, 1'b0);
    tick();
    m1_psel = 1'b0; m0_penable = 1'b1; s_pready = 1'b1;
    tick();
    drop_all();
    tick();

    // Abort: m1 wins a tie, drops psel, and should win the next tie again.
    m0_psel = 1'b1; m1_psel = 1'b1;
    settle();
    chk("t6_tie_gnt", gnt, 1'b1);
    tick();
    m1_psel = 1'b0;
    settle();
    chk("t6_abort_s_psel", s_psel, 1'b0);
    chk("t6_abort_m0_pready", m0_pready, 1'b0);
    tick();
    m1_psel = 1'b1;
    settle();
    chk("t6_retie_busy", busy, 1'b0);
    chk("t6_retie_gnt", gnt, 1'b1);
    tick();
    m1_penable = 1'b1; s_pready = 1'b1;
    tick();
    drop_all();
    tick();

    // Single-cycle transfer with error completes without entering BUSY.
    m0_psel = 1'b1; m0_penable = 1'b1; s_pready = 1'b1; s_perr = 1'b1;
    settle();
    chk("t7_single_pready", m0_pready, 1'b1);
    chk("t7_single_perr", m0_perr, 1'b1);
    tick();
    drop_all();
    settle();
    chk("t7_single_idle", busy, 1'b0);
    tick();

`ifdef APB_ARB_TIMEOUT_EN
    // Watchdog: slave never ready, terminated on the 16th access cycle.
    m0_psel = 1'b1; s_prdata = 32'hDEAD_BEEF;
    tick();
    m0_penable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      settle();
      chk("t5_wait_pready", m0_pready, (i == 16) ? 1'b1 : 1'b0);
      chk("t5_wait_perr", m0_perr, (i == 16) ? 1'b1 : 1'b0);
      tick();
    end
    m0_penable = 1'b0;
    settle();
    chk("t5_block_s_psel", s_psel, 1'b0);
    chk("t5_block_busy", busy, 1'b0);
    tick();
    settle();
    chk("t5_unblock_s_psel", s_psel, 1'b1);
    tick();
    drop_all();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-master APB arbiter sharing the single system APB slave port between the CPU control unit (master 0) and a secondary master such as DMA or debug (master 1). It forwards the winning master's APB signals to the slave with zero added latency and holds ownership until that transfer completes. The losing master is stalled with pready low. Ties are resolved round-robin, and an optional watchdog terminates hung transfers.

## Interface
Parameters:
- ADDR_W, 32, paddr width
- DATA_W, 32, pwdata/prdata width
- TIMEOUT, 16, watchdog limit in access cycles (≥2); used only with APB_ARB_TIMEOUT_EN

Ports (N ∈ {0,1}, one port set per master):
- APB_PCLK  input  1  clock; all state updates on its rising edge
- APB_PRESET  input  1  reset, synchronous, active-high
- mN_psel  input  1  master N select/request
- mN_penable  input  1  master N enable
- mN_pwrite  input  1  master N write
- mN_paddr  input  ADDR_W  master N address
- mN_pwdata  input  DATA_W  master N write data
- mN_prdata  output  DATA_W  read data to master N
- mN_pready  output  1  ready to master N
- mN_perr  output  1  error to master N
- s_psel, s_penable, s_pwrite  output  1  slave control
- s_paddr  output  ADDR_W  slave address
- s_pwdata  output  DATA_W  slave write data
- s_prdata  input  DATA_W  slave read data
- s_pready  input  1  slave ready
- s_perr  input  1  slave error
- gnt  output  1  current/selected owner (0 = m0, 1 = m1)
- busy  output  1  state == BUSY

## Operation
- Registered state: `state` {IDLE, BUSY}, `owner` (1 bit), `last` (last master served), and, with the macro, `wdog` counter of width clog2(TIMEOUT).
- Selection in IDLE (combinational):
  - Only one psel high: that master wins.
  - Both high: the master ≠ `last` wins.
  - Neither high: gnt = `owner`.
- Selection in BUSY: gnt = `owner`.
- Routing:
  - s_* = granted master's psel/penable/pwrite/paddr/pwdata.
  - Granted master receives s_prdata/s_pready/s_perr.
  - Non-granted master receives prdata = 0, pready = 0, perr = 0.
- Completion: done = s_psel & s_penable & s_pready.
- IDLE transitions:
  - Request present and done in the same cycle: stay IDLE; `last` ← gnt.
  - Request present without done: → BUSY; `owner` ← gnt.
- BUSY transitions:
  - done: → IDLE; `last` ← `owner`.
  - Owner drops psel without done (abort): → IDLE; `last` unchanged.
- A request from the other master while BUSY is ignored until the cycle after the state returns to IDLE.
- Reset, synchronous, takes priority over everything, including mid-transfer:
  - `state` = IDLE, `owner` = 0, `last` = 1 (m0 wins the first tie), `wdog` = 0.
  - While APB_PRESET is high, all outputs are forced to 0: s_psel, s_penable, m0/m1 pready, and the rest.

## Timing
- Zero-cycle pass-through for the granted master; no added wait states.
- Single-cycle transfers (psel = penable = pready in one cycle) complete without entering BUSY.
- Back-to-back requests from one master while the other master also requests alternate strictly after each completion.
- Loser stall: at least one cycle beyond the winner's done cycle.
- Outputs are combinational from state and inputs; there is no output register.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - `wdog` increments each cycle in which s_psel & s_penable & !s_pready, and clears otherwise.
  - In the cycle where `wdog` == TIMEOUT-1 and s_pready is still low, the owner sees pready = 1, perr = 1, prdata = 0.
  - The arbiter then → IDLE, `last` ← `owner`, and forces s_psel = 0 for exactly the following cycle.
- Undefined: no watchdog, `wdog` absent, and the arbiter waits indefinitely for s_pready.

## Test plan
- Reset then m0 read of 0x10, slave s_pready=1 on the first access cycle with s_prdata=0xA5A5A5A5 -> m0_prdata=0xA5A5A5A5 and m0_pready=1 that cycle; state returns IDLE; m1 outputs stay 0.
- m0 and m1 request in the same cycle after reset -> gnt=0 first; m1_pready=0 until one cycle after m0's done; then gnt=1; next tie -> gnt=0.
- m1 owns the bus, slave inserts 3 wait states, m0 raises psel mid-transfer -> s_paddr stays m1_paddr for all 4 access cycles; m0 is granted only afterward.
- APB_PRESET asserted while BUSY with m1 owner -> next cycle state=IDLE, s_psel=0; the first subsequent tie goes to m0.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=16, the slave never asserts ready -> on the 16th access cycle owner pready=1, perr=1; s_psel=0 the next cycle.
- Owner drops psel before done (abort) -> IDLE next cycle; `last` unchanged, so a following tie goes to the same master as before.
